// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: holds the port for init, then grants refresh/write/read one at a time
// and drives the registered SDRAM command, bank and address pins from the granted requester.
module sdram_arbit #(
    parameter int REF_CYCLES = 750,
    parameter int ADDR_W     = 12,
    parameter int BANK_W     = 2
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              init_done,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [3:0]        ref_cmd,
    input  logic [BANK_W-1:0] ref_bank,
    input  logic [ADDR_W-1:0] ref_addr,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              ref_end,
    input  logic              wr_end,
    input  logic              rd_end,
    output logic              ref_req,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cs,
    output logic              sdram_ras,
    output logic              sdram_cas,
    output logic              sdram_we,
    output logic [BANK_W-1:0] sdram_bank,
    output logic [ADDR_W-1:0] sdram_addr
);

    localparam int              CNT_W    = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REF_CYCLES - 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_ARBIT = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    localparam logic [3:0] CMD_NOP = 4'b0111;

    logic [2:0]        state_q, state_d;
    logic              init_done_q, init_done_d;
    logic              last_wr_q, last_wr_d;
    logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              ref_req_q, ref_req_d;
    logic              ref_en_q, ref_en_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ref_wrap_s;
    logic              ref_enter_s;

    // Next-state decision and round-robin bookkeeping
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        case (state_q)
            S_INIT: begin
                if (init_done) state_d = S_ARBIT;
                else           state_d = S_INIT;
            end
            S_ARBIT: begin
                if (ref_req_q)             state_d = S_AREF;
                else if (wr_req && rd_req) state_d = last_wr_q ? S_READ : S_WRITE;
                else if (wr_req)           state_d = S_WRITE;
                else if (rd_req)           state_d = S_READ;
                else                       state_d = S_ARBIT;
            end
            S_AREF: begin
                if (ref_end) state_d = S_ARBIT;
                else         state_d = S_AREF;
            end
            S_WRITE: begin
                if (wr_end) begin
                    state_d   = S_ARBIT;
                    last_wr_d = 1'b1;
                end else begin
                    state_d   = S_WRITE;
                end
            end
            S_READ: begin
                if (rd_end) begin
                    state_d   = S_ARBIT;
                    last_wr_d = 1'b0;
                end else begin
                    state_d   = S_READ;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Refresh timer and pending-refresh flag; a wrap on the AREF entry edge re-arms the flag
    always_comb begin
        init_done_d = init_done_q | ((state_q == S_INIT) & init_done);
        ref_wrap_s  = init_done_q && (ref_cnt_q == REF_LAST);
        ref_enter_s = (state_d == S_AREF) && (state_q != S_AREF);
        if (!init_done_q)   ref_cnt_d = {CNT_W{1'b0}};
        else if (ref_wrap_s) ref_cnt_d = {CNT_W{1'b0}};
        else                 ref_cnt_d = ref_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (ref_wrap_s)       ref_req_d = 1'b1;
        else if (ref_enter_s) ref_req_d = 1'b0;
        else                  ref_req_d = ref_req_q;
    end

    // Grants are registered from the next state so they track the state register exactly
    always_comb begin
        ref_en_d = (state_d == S_AREF);
        wr_en_d  = (state_d == S_WRITE);
        rd_en_d  = (state_d == S_READ);
    end

    // Pin mux selected by the current state
    always_comb begin
        case (state_q)
            S_INIT: begin
                cmd_d = init_cmd; bank_d = init_bank; addr_d = init_addr;
            end
            S_AREF: begin
                cmd_d = ref_cmd;  bank_d = ref_bank;  addr_d = ref_addr;
            end
            S_WRITE: begin
                cmd_d = wr_cmd;   bank_d = wr_bank;   addr_d = wr_addr;
            end
            S_READ: begin
                cmd_d = rd_cmd;   bank_d = rd_bank;   addr_d = rd_addr;
            end
            default: begin
                cmd_d = CMD_NOP; bank_d = {BANK_W{1'b0}}; addr_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, timer, grant and pin registers
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_INIT;
            init_done_q <= 1'b0;
            last_wr_q   <= 1'b0;
            ref_cnt_q   <= {CNT_W{1'b0}};
            ref_req_q   <= 1'b0;
            ref_en_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            cmd_q       <= CMD_NOP;
            bank_q      <= {BANK_W{1'b0}};
            addr_q      <= {ADDR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
            last_wr_q   <= last_wr_d;
            ref_cnt_q   <= ref_cnt_d;
            ref_req_q   <= ref_req_d;
            ref_en_q    <= ref_en_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            cmd_q       <= cmd_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
        end
    end

    assign ref_req    = ref_req_q;
    assign ref_en     = ref_en_q;
    assign wr_en      = wr_en_q;
    assign rd_en      = rd_en_q;
    assign sdram_cs   = cmd_q[3];
    assign sdram_ras  = cmd_q[2];
    assign sdram_cas  = cmd_q[1];
    assign sdram_we   = cmd_q[0];
    assign sdram_bank = bank_q;
    assign sdram_addr = addr_q;

endmodule
